core_inst_gen: RTL and testbench
================================

// Module: core_inst_gen
// PURPOSE
// - Instruction sequencer for the core: generates the 47-bit inst word that drives SRAM enables and addresses, L0 rd/wr, PE load/execute, OFIFO read and SFP valid.
// - Runs one full conv pass over N_KIJ kernel positions: weights->L0->PE, acts->L0->execute, OFIFO drain->psum SRAM, optional SFP accumulate.
// - Sits beside core; replaces the bench-driven inst stream. Its only input from core is ofifo_valid.
// PARAMETERS
// - COL      8   PE columns; weight vectors per kernel load
// - N_X      36  activation vectors per kij; also outputs drained per kij
// - N_KIJ    9   kernel positions per pass
// - ADDR_W   11  SRAM address width
// - LD_WAIT  8   idle cycles after kernel load, for PE propagation
// PORTS
// - clk          in   1   clock
// - reset        in   1   synchronous, active-high
// - start        in   1   1-cycle pulse; accepted only in IDLE
// - ofifo_valid  in   1   core OFIFO holds a full output row
// - inst         out  47  core instruction word
// - busy         out  1   high from the cycle after start until DONE
// - done         out  1   1-cycle pulse at pass end
// BEHAVIOUR
// - Clock and reset: one clock, clk. Reset is synchronous and active-high; all outputs and state are registered.
// - inst fields: [0] kernel load, [1] execute, [2] L0 wr from act, [3]/[4] L0 rd, [5] L0 wr from weight, [6] ofifo_rd.
// - inst fields, continued: [17:7]/[18]/[19] wmem A/WEN/CEN; [30:20]/[31]/[32] psum A/WEN/CEN; [33] sfp valid; [44:34]/[45]/[46] xmem A/WEN/CEN.
// - SRAM enables are active-low. IDLE_INST = 47'h6001_800C_0000: all CEN/WEN=1, all other bits 0.
// - Reset: go to IDLE; inst=IDLE_INST, busy=0, done=0, all counters 0. Applies mid-pass too; there is no partial resume.
// - The generator never writes wmem or xmem: [18]/[45] stay 1.
// - FSM per kij k=0..N_KIJ-1:
// - W_LD: cycles i=0..COL: for i<COL, wmem CEN=0, A=k*COL+i. For i>=1, [5]=1 (SRAM read latency 1). COL+1 cycles total.
// - K_LD: [4]=1, [0]=1 for COL cycles, then LD_WAIT cycles of IDLE_INST.
// - X_LD: same pattern as W_LD on xmem, A=i, i<N_X. [2]=1 is delayed one cycle. N_X+1 cycles.
// - EXEC: [3]=1, [1]=1 for N_X cycles.
// - DRAIN: per entry j=0..N_X-1, wait for ofifo_valid=1. In that cycle [6]=1 and psum CEN=0, WEN=0, A=k*N_X+j.
// - DRAIN with ofifo_valid=0: IDLE_INST, no count advance. There is no timeout.
// - After the last kij: SFP phase (if enabled) -> DONE -> IDLE.
// - DONE: done=1 for one cycle; busy falls in the same cycle.
// - start outside IDLE is ignored. start and reset together: reset wins.
// - Counters saturate at their terminal value and never wrap. Psum address k*N_X+j must fit in ADDR_W; check by elaboration assertion.
// CONFIGURATION
// - SFP_ACC_EN defined: after the last drain, SFP phase reads psum A=0..N_KIJ*N_X-1 (CEN=0, WEN=1), one per cycle. [33]=1 one cycle after each read. Length N_KIJ*N_X+1 cycles, then DONE.
// - SFP_ACC_EN undefined: no SFP phase; [33] is tied 0; DONE directly follows the final DRAIN.
// STRUCTURE
// - core_pkg: inst bit-position localparams, IDLE_INST, state enum (IDLE,W_LD,K_LD,X_LD,EXEC,DRAIN,SFP,DONE).
// - Sub-module phase_cnt: loadable up-counter with terminal-count flag and a 1-cycle delayed "valid" tap. Instanced for the i/j index and the kij index.
// TESTING
// - Reset: hold reset 3 cycles mid-EXEC -> next cycle inst=IDLE_INST, busy=0, done=0; a later start runs a full pass.
// - W_LD, k=2, COL=8: wmem A=16..23 on consecutive cycles with [19]=0. [5]=1 on the 8 cycles lagging by one; [2]=0 throughout.
// - X_LD/EXEC, N_X=36: xmem A=0..35, then [2] lags by one. EXEC has exactly 36 cycles with [3]=[1]=1.
// - DRAIN stall: ofifo_valid low 5 cycles then high -> no [6] while low; first write at psum A=k*36, WEN=0, with [6]=1 in the same cycle.
// - Full pass, SFP_ACC_EN undefined: 9*36=324 psum writes, [33] never set, one done pulse, 0 cycles from the final DRAIN.
// - Full pass, SFP_ACC_EN defined: 324 psum reads A=0..323, [33] delayed one cycle, then done. start during busy is ignored.

Source files
------------

// File: rtl/core_pkg.sv
// Instruction-word bit map, idle word and FSM state codes shared by the core instruction generator.
package core_pkg;

  localparam int INST_W = 47;
  localparam int A_W    = 11;

  localparam int B_KLD    = 0;
  localparam int B_EXEC   = 1;
  localparam int B_L0_WA  = 2;
  localparam int B_L0_RD0 = 3;
  localparam int B_L0_RD1 = 4;
  localparam int B_L0_WW  = 5;
  localparam int B_OF_RD  = 6;
  localparam int B_W_A    = 7;
  localparam int B_W_WEN  = 18;
  localparam int B_W_CEN  = 19;
  localparam int B_P_A    = 20;
  localparam int B_P_WEN  = 31;
  localparam int B_P_CEN  = 32;
  localparam int B_SFP    = 33;
  localparam int B_X_A    = 34;
  localparam int B_X_WEN  = 45;
  localparam int B_X_CEN  = 46;

  // All SRAM CEN/WEN high (active-low), every strobe low.
  localparam logic [INST_W-1:0] IDLE_INST = 47'h6001_800C_0000;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_W_LD  = 3'd1;
  localparam logic [2:0] ST_K_LD  = 3'd2;
  localparam logic [2:0] ST_X_LD  = 3'd3;
  localparam logic [2:0] ST_EXEC  = 3'd4;
  localparam logic [2:0] ST_DRAIN = 3'd5;
  localparam logic [2:0] ST_SFP   = 3'd6;
  localparam logic [2:0] ST_DONE  = 3'd7;

endpackage

// File: rtl/phase_cnt.sv
// Saturating loadable up-counter with terminal-count flag and a one-cycle delayed tap.
// clr wins over inc; the tap is simply tap_in registered.
module phase_cnt #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  input  logic         tap_in,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc,
  output logic         tap
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tap_q, tap_d;

  always_comb begin
    cnt_d = cnt_q;
    tap_d = tap_in;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != last)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tap_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tap_q <= tap_d;
    end
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == last);
  assign tap = tap_q;

endmodule

// File: rtl/core_inst_gen.sv
// Sequences one conv pass (W_LD, K_LD, X_LD, EXEC, DRAIN per kij); inst lags FSM state by one register.
// DRAIN stalls on ofifo_valid with no timeout; SFP_ACC_EN adds a psum read-back phase before DONE.
module core_inst_gen #(
  parameter int COL     = 8,
  parameter int N_X     = 36,
  parameter int N_KIJ   = 9,
  parameter int ADDR_W  = 11,
  parameter int LD_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ofifo_valid,
  output logic [46:0] inst,
  output logic        busy,
  output logic        done
);
  import core_pkg::*;

  localparam logic [ADDR_W-1:0] COL_A    = ADDR_W'(COL);
  localparam logic [ADDR_W-1:0] NX_A     = ADDR_W'(N_X);
  localparam logic [ADDR_W-1:0] NX_LAST  = ADDR_W'(N_X - 1);
  localparam logic [ADDR_W-1:0] KLD_LAST = ADDR_W'(COL + LD_WAIT - 1);
  localparam logic [ADDR_W-1:0] KIJ_LAST = ADDR_W'(N_KIJ - 1);
`ifdef SFP_ACC_EN
  localparam logic [ADDR_W-1:0] NSFP_A   = ADDR_W'(N_KIJ * N_X);
  localparam logic [2:0]        ST_POST  = ST_SFP;
`else
  localparam logic [2:0]        ST_POST  = ST_DONE;
`endif

  if (ADDR_W != A_W) begin : g_bad_addr_w
    $error("ADDR_W must equal the inst address field width");
  end
  if (N_KIJ * N_X > (1 << ADDR_W) - 1) begin : g_bad_psum
    $error("psum address range N_KIJ*N_X does not fit in ADDR_W");
  end
  if (N_KIJ * COL > (1 << ADDR_W)) begin : g_bad_wmem
    $error("wmem address range N_KIJ*COL does not fit in ADDR_W");
  end

  logic [2:0]        state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              busy_q, busy_d;

  logic              idx_clr, idx_inc, idx_tap_in, idx_tc, idx_tap;
  logic [ADDR_W-1:0] idx_last, idx;
  logic              kij_clr, kij_inc, kij_tc;
  logic [ADDR_W-1:0] kij;

  phase_cnt #(.W(ADDR_W)) u_idx (
    .clk    (clk),
    .reset  (reset),
    .clr    (idx_clr),
    .inc    (idx_inc),
    .tap_in (idx_tap_in),
    .last   (idx_last),
    .cnt    (idx),
    .tc     (idx_tc),
    .tap    (idx_tap)
  );

  // The pass counter's delayed tap doubles as the registered done pulse.
  phase_cnt #(.W(ADDR_W)) u_kij (
    .clk    (clk),
    .reset  (reset),
    .clr    (kij_clr),
    .inc    (kij_inc),
    .tap_in (state_q == ST_DONE),
    .last   (KIJ_LAST),
    .cnt    (kij),
    .tc     (kij_tc),
    .tap    (done)
  );

  always_comb begin
    state_d  = state_q;
    idx_clr  = 1'b0;
    idx_inc  = 1'b1;
    idx_last = '0;
    kij_clr  = 1'b0;
    kij_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        idx_inc = 1'b0;
        if (start) begin
          state_d = ST_W_LD;
          idx_clr = 1'b1;
          kij_clr = 1'b1;
        end
      end
      ST_W_LD: begin
        idx_last = COL_A;
        if (idx_tc) begin
          state_d = ST_K_LD;
          idx_clr = 1'b1;
        end
      end
      ST_K_LD: begin
        idx_last = KLD_LAST;
        if (idx_tc) begin
          state_d = ST_X_LD;
          idx_clr = 1'b1;
        end
      end
      ST_X_LD: begin
        idx_last = NX_A;
        if (idx_tc) begin
          state_d = ST_EXEC;
          idx_clr = 1'b1;
        end
      end
      ST_EXEC: begin
        idx_last = NX_LAST;
        if (idx_tc) begin
          state_d = ST_DRAIN;
          idx_clr = 1'b1;
        end
      end
      ST_DRAIN: begin
        idx_last = NX_LAST;
        idx_inc  = ofifo_valid;
        if (ofifo_valid && idx_tc) begin
          idx_clr = 1'b1;
          if (kij_tc) begin
            state_d = ST_POST;
          end else begin
            kij_inc = 1'b1;
            state_d = ST_W_LD;
          end
        end
      end
`ifdef SFP_ACC_EN
      ST_SFP: begin
        idx_last = NSFP_A;
        if (idx_tc) begin
          state_d = ST_DONE;
          idx_clr = 1'b1;
        end
      end
`endif
      ST_DONE: begin
        idx_inc = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // SRAM reads have one cycle of latency, so each L0/SFP strobe rides the delayed tap.
  always_comb begin
    inst_d     = IDLE_INST;
    idx_tap_in = 1'b0;
    case (state_q)
      ST_W_LD: begin
        if (idx < COL_A) begin
          inst_d[B_W_CEN]          = 1'b0;
          inst_d[B_W_A +: ADDR_W]  = kij * COL_A + idx;
          idx_tap_in               = 1'b1;
        end
        inst_d[B_L0_WW] = idx_tap;
      end
      ST_K_LD: begin
        if (idx < COL_A) begin
          inst_d[B_L0_RD1] = 1'b1;
          inst_d[B_KLD]    = 1'b1;
        end
      end
      ST_X_LD: begin
        if (idx < NX_A) begin
          inst_d[B_X_CEN]         = 1'b0;
          inst_d[B_X_A +: ADDR_W] = idx;
          idx_tap_in              = 1'b1;
        end
        inst_d[B_L0_WA] = idx_tap;
      end
      ST_EXEC: begin
        inst_d[B_L0_RD0] = 1'b1;
        inst_d[B_EXEC]   = 1'b1;
      end
      ST_DRAIN: begin
        if (ofifo_valid) begin
          inst_d[B_OF_RD]         = 1'b1;
          inst_d[B_P_CEN]         = 1'b0;
          inst_d[B_P_WEN]         = 1'b0;
          inst_d[B_P_A +: ADDR_W] = kij * NX_A + idx;
        end
      end
`ifdef SFP_ACC_EN
      ST_SFP: begin
        if (idx < NSFP_A) begin
          inst_d[B_P_CEN]         = 1'b0;
          inst_d[B_P_A +: ADDR_W] = idx;
          idx_tap_in              = 1'b1;
        end
        inst_d[B_SFP] = idx_tap;
      end
`endif
      default: inst_d = IDLE_INST;
    endcase
  end

  always_comb begin
    busy_d = (state_q == ST_IDLE) ? start : (state_q != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      inst_q  <= IDLE_INST;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_core_inst_gen.sv
// Directed bench for core_inst_gen: reset, W_LD/X_LD/EXEC sequencing, drain stall and full-pass accounting.
module tb_core_inst_gen;

  localparam logic [46:0] IDLE_W = 47'h6001_800C_0000;
`ifdef SFP_ACC_EN
  localparam int EXP_DONE_M = 1533;
  localparam int EXP_RDS    = 324;
`else
  localparam int EXP_DONE_M = 1208;
  localparam int EXP_RDS    = 0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [46:0] inst;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  core_inst_gen dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic pulse_start;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (done !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done_timeout: done=%b after %0d cycles, want 1", name, done, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (inst !== IDLE_W) begin errors++; $display("FAIL reset_inst: got %h want %h", inst, IDLE_W); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || inst !== IDLE_W) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b inst=%h want 0 %h", busy, inst, IDLE_W);
    end
  endtask

  task automatic test_reset_mid_exec;
    int n = 0;
    int bad = 0;
    ofifo_valid = 1'b1;
    pulse_start();
    while (inst[1] !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (inst[1] !== 1'b1) begin errors++; $display("FAIL midexec_reach: exec=%b want 1", inst[1]); end
    repeat (5) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) start = 1'b1;
      @(negedge clk);
      checks++;
      if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL midexec_reset%0d: inst=%h busy=%b done=%b want %h 0 0", c, inst, busy, done, IDLE_W);
      end
    end
    reset = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_beats_start: %0d non-idle cycles, want 0", bad); end
  endtask

  task automatic test_w_ld;
    int n = 0;
    logic [13:0] got, exp;
    ofifo_valid = 1'b1;
    pulse_start();
    while (!(inst[19] === 1'b0 && inst[17:7] === 11'd16) && n < 1000) begin @(negedge clk); n++; end
    checks++;
    if (n >= 1000) begin errors++; $display("FAIL wld_k2_reach: wmem A=%0d cen=%b want 16 0", inst[17:7], inst[19]); end
    for (int i = 0; i <= 8; i++) begin
      got = {inst[19], inst[17:7], inst[5], inst[2]};
      exp = {(i >= 8), (i < 8) ? 11'(16 + i) : 11'd0, (i >= 1), 1'b0};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL wld_k2_i%0d: {cen,A,wrw,wra}=%h want %h", i, got, exp);
      end
      @(negedge clk);
    end
    wait_done("wld");
  endtask

  task automatic test_x_exec;
    int n = 0;
    int bad = 0;
    int e = 0;
    logic [13:0] got, exp;
    ofifo_valid = 1'b1;
    pulse_start();
    while (inst[46] !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    checks++;
    if (inst[46] !== 1'b0) begin errors++; $display("FAIL xld_reach: xmem cen=%b want 0", inst[46]); end
    for (int i = 0; i <= 36; i++) begin
      got = {inst[46], inst[44:34], inst[2], inst[5]};
      exp = {(i >= 36), (i < 36) ? 11'(i) : 11'd0, (i >= 1), 1'b0};
      if (got !== exp) bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL xld_seq: %0d bad X_LD cycles, want 0", bad); end
    while (inst[1] === 1'b1 && inst[3] === 1'b1 && e < 100) begin @(negedge clk); e++; end
    checks++;
    if (e != 36) begin errors++; $display("FAIL exec_len: %0d exec cycles, want 36", e); end
    wait_done("xexec");
  endtask

  task automatic test_drain_stall;
    int n;
    int bad;
    logic [13:0] got, exp;
    ofifo_valid = 1'b0;
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (inst[1] !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      n = 0;
      while (inst[1] !== 1'b0 && n < 100) begin @(negedge clk); n++; end
      checks++;
      if (n >= 100 || inst[1] !== 1'b0) begin errors++; $display("FAIL stall_k%0d_reach: exec=%b", k, inst[1]); end
      bad = 0;
      for (int c = 0; c < 5; c++) begin
        if (inst !== IDLE_W) bad++;
        @(negedge clk);
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL stall_k%0d_idle: %0d non-idle cycles, want 0", k, bad); end
      ofifo_valid = 1'b1;
      for (int j = 0; j < 36; j++) begin
        @(negedge clk);
        got = {inst[6], inst[32], inst[31], inst[30:20]};
        exp = {1'b1, 1'b0, 1'b0, 11'(k * 36 + j)};
        if (j == 0) begin
          checks++;
          if (got !== exp) begin errors++; $display("FAIL stall_k%0d_first: {ofrd,cen,wen,A}=%h want %h", k, got, exp); end
        end else if (got !== exp) begin
          bad++;
        end
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL stall_k%0d_writes: %0d bad writes, want 0", k, bad); end
      ofifo_valid = 1'b0;
    end
    ofifo_valid = 1'b1;
    wait_done("stall");
  endtask

  task automatic test_full_pass;
    int m = 1;
    int wr_cnt = 0, rd_cnt = 0, last_ev = 0;
    int bad_wr = 0, bad_rd = 0, bad_sfp = 0, bad_wen = 0, bad_busy = 0;
    logic prev_rd = 1'b0;
    logic wr, rd;
    ofifo_valid = 1'b1;
    pulse_start();
    while (done !== 1'b1 && m < 4000) begin
      wr = (inst[32] === 1'b0) && (inst[31] === 1'b0);
      rd = (inst[32] === 1'b0) && (inst[31] === 1'b1);
      if (wr) begin
        if (inst[30:20] !== 11'(wr_cnt) || inst[6] !== 1'b1) bad_wr++;
        wr_cnt++;
        last_ev = m;
      end else if (inst[6] !== 1'b0) begin
        bad_wr++;
      end
      if (rd) begin
        if (inst[30:20] !== 11'(rd_cnt)) bad_rd++;
        rd_cnt++;
        last_ev = m + 1;
      end
      if (inst[33] !== prev_rd) bad_sfp++;
      prev_rd = rd;
      if (inst[18] !== 1'b1 || inst[45] !== 1'b1) bad_wen++;
      if (busy !== 1'b1) bad_busy++;
      start = (m == 100);
      @(negedge clk);
      m++;
    end
    start = 1'b0;
    checks++;
    if (m != EXP_DONE_M) begin errors++; $display("FAIL pass_len: done at cycle %0d, want %0d", m, EXP_DONE_M); end
    checks++;
    if (wr_cnt != 324 || bad_wr != 0) begin
      errors++;
      $display("FAIL psum_writes: count=%0d bad=%0d, want 324 0", wr_cnt, bad_wr);
    end
    checks++;
    if (rd_cnt != EXP_RDS || bad_rd != 0) begin
      errors++;
      $display("FAIL psum_reads: count=%0d bad=%0d, want %0d 0", rd_cnt, bad_rd, EXP_RDS);
    end
    checks++;
    if (bad_sfp != 0) begin errors++; $display("FAIL sfp_valid: %0d bad cycles, want 0", bad_sfp); end
    checks++;
    if (bad_wen != 0) begin errors++; $display("FAIL wx_wen: %0d cycles with write enabled, want 0", bad_wen); end
    checks++;
    if (bad_busy != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pass_busy: %0d low cycles, busy at done=%b, want 0 0", bad_busy, busy);
    end
    checks++;
    if (m != last_ev + 1) begin errors++; $display("FAIL done_gap: done at %0d, last event %0d, want +1", m, last_ev); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || inst !== IDLE_W) begin
      errors++;
      $display("FAIL post_done: done=%b busy=%b inst=%h want 0 0 %h", done, busy, inst, IDLE_W);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_reset_mid_exec();
    test_w_ld();
    test_x_exec();
    test_drain_stall();
    test_full_pass();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
